// File: rtl/pulse_train_ctrl.sv
// rtl/pulse_train_ctrl.sv - pulse train sequencer driving an external time-base counter
// Each high/low phase arms the time base with a terminal count and advances on its end-of-count.
module pulse_train_ctrl #(
  parameter int N     = 8,
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [W_CNT-1:0] pulses,
  input  logic [N-1:0]     t_high,
  input  logic [N-1:0]     t_low,
  input  logic             tb_eo,
  output logic             tb_st,
  output logic [N-1:0]     tb_dat,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {IDLE, HIGH, LOW, FLUSH, DONE} state_t;

  state_t           state_q;
  logic [W_CNT-1:0] pulses_q;
  logic [W_CNT-1:0] cnt_q;
  logic [N-1:0]     t_high_q;
  logic [N-1:0]     t_low_q;
  logic             eo_seen_q;
  logic             tb_st_q;
  logic [N-1:0]     tb_dat_q;
  logic             pulse_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pulses_q  <= '0;
      cnt_q     <= '0;
      t_high_q  <= '0;
      t_low_q   <= '0;
      eo_seen_q <= 1'b0;
      tb_st_q   <= 1'b0;
      tb_dat_q  <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (pulses != '0) begin
              pulses_q <= pulses;
              t_high_q <= t_high;
              t_low_q  <= t_low;
              cnt_q    <= '0;
              state_q  <= HIGH;
              tb_st_q  <= 1'b1;
              tb_dat_q <= t_high;
              pulse_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        HIGH, LOW: begin
          if (abort) begin
            // If the phase ends on this very edge the time base clears now; stop it
            // so it stays at 0 through the single FLUSH cycle.
            state_q   <= FLUSH;
            pulse_q   <= 1'b0;
            eo_seen_q <= tb_eo;
            if (tb_eo) tb_st_q <= 1'b0;
          end else if (tb_eo) begin
            if (state_q == HIGH) begin
              state_q  <= LOW;
              tb_dat_q <= t_low_q;
              pulse_q  <= 1'b0;
            end else if (cnt_q == pulses_q - W_CNT'(1)) begin
              state_q  <= DONE;
              tb_st_q  <= 1'b0;
              tb_dat_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cnt_q    <= cnt_q + W_CNT'(1);
              state_q  <= HIGH;
              tb_dat_q <= t_high_q;
              pulse_q  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (tb_eo || eo_seen_q) begin
            state_q   <= IDLE;
            eo_seen_q <= 1'b0;
            tb_st_q   <= 1'b0;
            tb_dat_q  <= '0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tb_st     = tb_st_q;
  assign tb_dat    = tb_dat_q;
  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: doc/pulse_train_ctrl.md
Name: pulse_train_ctrl

Overview:
- Sequencer that sits directly upstream of the time-base counter (stBT/dat/eoBT interface) and drives it.
- Generates a train of `pulses` output pulses, each with a programmable high time and low time.
- Each phase is timed by arming the time base with a terminal count and waiting for its end-of-count strobe.
- Reports busy/done/aborted status to the top-level control logic.

Parameters:
- N, 8, width of the time-base terminal count (t_high, t_low, tb_dat).
- W_CNT, 8, width of the pulse-count field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel request.
- pulses  in  W_CNT  number of pulses to generate; latched on accepted start.
- t_high  in  N  high-phase terminal count; latched on accepted start.
- t_low  in  N  low-phase terminal count; latched on accepted start.
- tb_eo  in  1  end-of-count from the time base (its eoBT).
- tb_st  out  1  enable to the time base (its stBT); registered.
- tb_dat  out  N  terminal count to the time base (its dat); registered.
- pulse_out  out  1  generated pulse train; registered.
- busy  out  1  high while a train or flush is in progress.
- done  out  1  one-cycle strobe when a train completes normally.
- aborted  out  1  one-cycle strobe when an abort flush completes.

Behaviour:
- Reset (async): state=IDLE; tb_st, tb_dat, pulse_out, busy, done, aborted all 0; latched config and pulse counter cleared.

Time-base contract (drives the design; do not violate):
- The counter increments while tb_st=1.
- tb_eo is combinational, asserted while count==tb_dat.
- On the edge after tb_eo the counter returns to 0, regardless of tb_st.
- With tb_st=0 the counter holds; it never clears by itself.
- Therefore a phase with terminal count T lasts T+1 cycles.
- tb_dat must only change on the edge that consumes tb_eo.

States: IDLE, HIGH, LOW, FLUSH, DONE.
- IDLE:
  - tb_eo ignored; tb_dat=0, so tb_eo may sit high.
  - start=1 with pulses!=0: latch config, cnt=0, go to HIGH; on that edge tb_st=1, tb_dat=t_high, pulse_out=1, busy=1.
  - start=1 with pulses==0: go to DONE directly; no time-base activity.
- HIGH: tb_eo=1 → LOW; tb_dat=t_low_lat, pulse_out=0, tb_st stays 1.
- LOW: tb_eo=1:
  - If cnt==pulses_lat-1 → DONE: tb_st=0, tb_dat=0, busy=0.
  - Else cnt+1 → HIGH: tb_dat=t_high_lat, pulse_out=1.
- DONE: done=1 for exactly one cycle → IDLE.
- abort=1 in HIGH or LOW:
  - Next edge: pulse_out=0, state FLUSH.
  - tb_st stays 1 and tb_dat is unchanged, so the time base runs to its current terminal count and self-clears.
- FLUSH:
  - busy=1; on tb_eo → IDLE with tb_st=0, tb_dat=0, busy=0, aborted=1 for one cycle.
  - Abort latency is bounded by the current phase length.
- abort in IDLE, DONE or FLUSH: no effect.
- Priority in HIGH/LOW: abort beats tb_eo when both are asserted on the same cycle; go to FLUSH.
  - The time base has already hit its terminal count and clears on that edge.
  - The FLUSH exit condition is therefore satisfied by that tb_eo: FLUSH tracks tb_eo seen-or-pending via a flag set when abort and tb_eo coincide, and exits on the next cycle.
- start while busy or in DONE: ignored; config inputs are not re-sampled.
- Zero-length phases: t_high=0 or t_low=0 gives a 1-cycle phase (tb_eo on the first cycle).
- Train length, start edge to done edge: pulses_lat*(t_high+t_low+2) cycles.
- Arithmetic: cnt is W_CNT bits and never wraps, because the compare against pulses_lat-1 occurs first. pulses_lat ≥ 1 in HIGH/LOW.
- Mid-operation reset: all outputs drop asynchronously. The time base shares rst, so no flush is needed.

Test Plan:
- Reset then idle 10 cycles → all outputs 0; tb_eo toggling has no effect.
- pulses=2, t_high=3, t_low=1, start at edge 0:
  - pulse_out=1 for edges 0–4, 0 for edges 4–6, 1 for edges 6–10, 0 for edges 10–12.
  - done=1 for edge 12–13 only; busy=1 for edges 0–12.
  - tb_dat sequence 3,1,3,1,0.
- pulses=0 with start → done strobe on the next cycle; tb_st never asserted; busy stays 0.
- pulses=1, t_high=0, t_low=0 → pulse_out high 1 cycle, low 1 cycle; done at edge 2.
- pulses=3, t_high=5, t_low=5, abort 2 cycles into the second HIGH:
  - pulse_out=0 at the next edge.
  - tb_st stays 1 until tb_eo, 4 cycles later.
  - aborted=1 for one cycle; done never asserted.
  - A restart with pulses=1, t_high=2, t_low=2 then behaves nominally (no residual count).
- abort coincident with tb_eo at the end of HIGH → FLUSH exits the next cycle with aborted=1. Assert the time-base count is 0 on exit.
